digit_scan_ctrl: RTL and testbench
==================================

// Module: digit_scan_ctrl
// PURPOSE
// - Sequencer for the 9-digit BCD counter bank. Snapshots all digit outputs
//   in one cycle so a frame never mixes digits from different counts.
// - Streams the snapshot one digit per transfer over valid/ready, MSD first,
//   to the display/serial stage.
// - Frames repeat while EN is high, with a programmable idle gap between frames.
// PARAMETERS
// - NDIG     9   number of digits in the bank (>=2)
// - DW       5   bits per digit; low 4 bits = BCD value, bit DW-1 = flag, passed through
// - GAP_CYC  4   idle cycles between frames (0 = back-to-back frames)
// PORTS
// - CLK        in   1         clock; all state changes on rising edge
// - RST        in   1         synchronous, active-high reset
// - EN         in   1         frame enable; sampled in IDLE and at every frame end
// - DIGITS     in   NDIG*DW   digit bank; digit i = DIGITS[i*DW +: DW]; i=0 is ones
// - OUT_READY  in   1         sink accepts OUT_DIGIT this cycle
// - OUT_VALID  out  1         OUT_DIGIT/OUT_IDX/OUT_FIRST/OUT_LAST valid
// - OUT_DIGIT  out  DW        current digit
// - OUT_IDX    out  4         index of current digit (NDIG-1 .. 0)
// - OUT_FIRST  out  1         high with the MSD (idx NDIG-1)
// - OUT_LAST   out  1         high with the ones digit (idx 0)
// - BUSY       out  1         high in SNAP/SEND/GAP
// - BCD_ERR    out  1         sticky; a snapshot held a digit with low nibble > 9
// - FRAME_CNT  out  8         completed frames, wraps 255 -> 0
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0: OUT_VALID, OUT_DIGIT, OUT_IDX, OUT_FIRST,
//   OUT_LAST, BUSY, BCD_ERR, FRAME_CNT. Snapshot register cleared. RST wins over all.
// - IDLE: if EN=1 -> SNAP next cycle, else stay.
// - SNAP (1 cycle):
//   - Capture DIGITS into the snapshot; idx <= NDIG-1; -> SEND.
//   - Set BCD_ERR if any captured low nibble > 9. Raw values are still sent.
// - SEND:
//   - OUT_VALID=1. OUT_DIGIT=snap[idx], OUT_IDX=idx, FIRST/LAST decoded from idx.
//   - Outputs are registered; the first digit is valid in the cycle after SNAP.
//   - Transfer = OUT_VALID & OUT_READY; idx decrements by 1 per transfer.
//   - While OUT_VALID & !OUT_READY, all OUT_* hold stable. No bubbles between
//     transfers: full throughput is 1 digit/cycle.
//   - Transfer with idx=0: FRAME_CNT+1, OUT_VALID drops next cycle. Then go to:
//     - GAP if GAP_CYC>0;
//     - else SNAP if EN=1;
//     - else IDLE.
// - GAP: count GAP_CYC cycles, then SNAP if EN=1, else IDLE.
// - EN falling mid-frame or mid-gap: current frame and gap complete, no new SNAP.
// - DIGITS changing during SEND has no effect on the frame in progress.
// - Frame latency, GAP_CYC=0, READY=1: NDIG+1 cycles per frame (SNAP + NDIG digits).
// - BCD_ERR clears only on RST.
// CONFIGURATION
// - LZ_BLANK_EN defined: leading-zero blanking.
//   - A digit is a leading zero when its low nibble is 0, idx>0, and every
//     higher-index digit in the same snapshot is also 0.
//   - Each leading zero is emitted as OUT_DIGIT = all ones (5'h1F).
//   - Transfer count, OUT_IDX, FIRST and LAST are unchanged.
// - LZ_BLANK_EN undefined: raw snapshot values only; no blanking logic built.
// TESTING
// - RST, EN=1, READY=1, DIGITS=123456789 BCD -> after SNAP, 9 consecutive
//   digits 1..9, IDX 8..0, FIRST with 1, LAST with 9, FRAME_CNT=1.
// - Backpressure:
//   - READY low 3 cycles at idx 5 -> OUT_DIGIT=4 and IDX=5 held stable.
//   - Frame then resumes with no lost or duplicated digits.
// - DIGITS changed to 000000042 mid-SEND:
//   - Current frame still outputs 123456789.
//   - Next frame outputs 000000042 (LZ_BLANK_EN: seven 5'h1F, then 4, 2).
// - GAP_CYC=4, EN held high -> exactly 4 idle cycles (BUSY=1, VALID=0) between
//   LAST transfer and next SNAP.
// - EN dropped at idx 3 -> frame finishes, then gap, then IDLE, BUSY=0.
// - RST mid-frame -> next cycle all outputs 0, state IDLE.
// - Digit nibble 4'hC -> BCD_ERR=1, digit still sent raw.
// - Run 256 frames -> FRAME_CNT wraps to 0.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
// Frame sequencer for a BCD counter bank. The whole bank is captured in a
// single SNAP cycle, then streamed MSD first, one digit per valid/ready
// transfer, with a programmable idle gap between frames.
// Optional build macro: LZ_BLANK_EN enables leading-zero blanking (each
// leading zero is sent as an all-ones code). Undefined by default.
module digit_scan_ctrl #(
  parameter int NDIG    = 9,
  parameter int DW      = 5,
  parameter int GAP_CYC = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [NDIG*DW-1:0] DIGITS,
  input  logic               OUT_READY,
  output logic               OUT_VALID,
  output logic [DW-1:0]      OUT_DIGIT,
  output logic [3:0]         OUT_IDX,
  output logic               OUT_FIRST,
  output logic               OUT_LAST,
  output logic               BUSY,
  output logic               BCD_ERR,
  output logic [7:0]         FRAME_CNT
);

  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [3:0]       IDX_MSD  = 4'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SNAP,
    S_SEND,
    S_GAP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NDIG*DW-1:0] snap_p0;
  logic [NDIG*DW-1:0] snap_in;
  logic [GAP_W-1:0]   gap_cnt;
  logic               xfer;
  logic               xfer_last;

  // Select digit idx out of a packed bank; out-of-range indices read as zero.
  function automatic logic [DW-1:0] pick_digit(input logic [NDIG*DW-1:0] bank,
                                               input logic [3:0]         idx);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == 4'(i)) d = bank[i*DW +: DW];
    end
    return d;
  endfunction

  // True when any digit's BCD nibble lies outside 0..9.
  function automatic logic has_bad_bcd(input logic [NDIG*DW-1:0] bank);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bank[i*DW +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

`ifdef LZ_BLANK_EN
  // Replace the run of zero nibbles starting at the MSD with all-ones codes.
  // The ones digit is never blanked so a zero count still shows one digit.
  function automatic logic [NDIG*DW-1:0] blank_lz(input logic [NDIG*DW-1:0] bank);
    logic [NDIG*DW-1:0] res;
    logic               zero_run;
    res      = bank;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      zero_run = zero_run & (bank[i*DW +: 4] == 4'd0);
      if (zero_run) res[i*DW +: DW] = '1;
    end
    return res;
  endfunction

  assign snap_in = blank_lz(DIGITS);
`else
  assign snap_in = DIGITS;
`endif

  assign xfer      = OUT_VALID & OUT_READY;
  assign xfer_last = xfer & (OUT_IDX == 4'd0);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; EN is only looked at when a new frame could start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (EN) state_nxt = S_SNAP;
      end
      S_SNAP: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (xfer_last) begin
          if (GAP_CYC > 0) state_nxt = S_GAP;
          else if (EN)     state_nxt = S_SNAP;
          else             state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = EN ? S_SNAP : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    BUSY = (state != S_IDLE);
  end

  // Gap cycle counter, held at zero outside the gap.
  always_ff @(posedge CLK) begin
    if (RST || state != S_GAP) gap_cnt <= '0;
    else                       gap_cnt <= gap_cnt + GAP_W'(1);
  end

  // ---- stage p0: snapshot capture and registered stream outputs ----
  // SNAP loads the bank and presents the MSD in the same edge; SEND advances
  // only on a transfer, so the outputs hold while the sink stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_p0   <= '0;
      OUT_VALID <= 1'b0;
      OUT_DIGIT <= '0;
      OUT_IDX   <= '0;
      OUT_FIRST <= 1'b0;
      OUT_LAST  <= 1'b0;
      BCD_ERR   <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      case (state)
        S_SNAP: begin
          snap_p0   <= snap_in;
          OUT_VALID <= 1'b1;
          OUT_DIGIT <= snap_in[(NDIG-1)*DW +: DW];
          OUT_IDX   <= IDX_MSD;
          OUT_FIRST <= 1'b1;
          OUT_LAST  <= 1'b0;
          BCD_ERR   <= BCD_ERR | has_bad_bcd(DIGITS);
        end
        S_SEND: begin
          if (xfer_last) begin
            OUT_VALID <= 1'b0;
            OUT_FIRST <= 1'b0;
            OUT_LAST  <= 1'b0;
            FRAME_CNT <= FRAME_CNT + 8'd1;
          end else if (xfer) begin
            OUT_IDX   <= OUT_IDX - 4'd1;
            OUT_DIGIT <= pick_digit(snap_p0, OUT_IDX - 4'd1);
            OUT_FIRST <= 1'b0;
            OUT_LAST  <= (OUT_IDX == 4'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Testbench for digit_scan_ctrl: directed frames with hand-computed digits.
module tb_digit_scan_ctrl;

  localparam int NDIG    = 9;
  localparam int DW      = 5;
  localparam int GAP_CYC = 4;
  localparam int BW      = NDIG * DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic          OUT_READY;
  logic [BW-1:0] DIGITS;

  logic          OUT_VALID;
  logic [DW-1:0] OUT_DIGIT;
  logic [3:0]    OUT_IDX;
  logic          OUT_FIRST;
  logic          OUT_LAST;
  logic          BUSY;
  logic          BCD_ERR;
  logic [7:0]    FRAME_CNT;

  logic          z_valid;
  logic [DW-1:0] z_digit;
  logic [3:0]    z_idx;
  logic          z_first;
  logic          z_last;
  logic          z_busy;
  logic          z_bcd_err;
  logic [7:0]    z_frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  digit_scan_ctrl #(.NDIG(NDIG), .DW(DW), .GAP_CYC(GAP_CYC)) u_dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIGITS(DIGITS), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .OUT_DIGIT(OUT_DIGIT), .OUT_IDX(OUT_IDX),
    .OUT_FIRST(OUT_FIRST), .OUT_LAST(OUT_LAST), .BUSY(BUSY),
    .BCD_ERR(BCD_ERR), .FRAME_CNT(FRAME_CNT)
  );

  // Second instance with no gap, for back-to-back frame timing.
  digit_scan_ctrl #(.NDIG(NDIG), .DW(DW), .GAP_CYC(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIGITS(DIGITS), .OUT_READY(OUT_READY),
    .OUT_VALID(z_valid), .OUT_DIGIT(z_digit), .OUT_IDX(z_idx),
    .OUT_FIRST(z_first), .OUT_LAST(z_last), .BUSY(z_busy),
    .BCD_ERR(z_bcd_err), .FRAME_CNT(z_frame_cnt)
  );

  function automatic logic [BW-1:0] to_bank(input logic [4*NDIG-1:0] bcd);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < NDIG; i++) b[i*DW +: 4] = bcd[i*4 +: 4];
    return b;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Receive one frame and check every digit against exp_bank. Optional hooks
  // stall the sink, change DIGITS or drop EN while a given digit is shown.
  task automatic recv_frame(input logic [BW-1:0] exp_bank, input int stall_idx,
                            input int chg_idx, input logic [BW-1:0] chg_bank,
                            input int drop_idx, input string tag);
    int            waited;
    logic [DW-1:0] ed;
    logic [DW+6:0] got;
    logic [DW+6:0] want;
    waited = 0;
    while (OUT_VALID !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    total++;
    if (OUT_VALID !== 1'b1) begin
      bad++;
      $display("FAIL %s start: OUT_VALID=%b after %0d cycles, required 1", tag, OUT_VALID, waited);
      return;
    end
    for (int k = NDIG - 1; k >= 0; k--) begin
      ed   = exp_bank[k*DW +: DW];
      want = {1'b1, ed, 4'(k), (k == NDIG - 1), (k == 0)};
      got  = {OUT_VALID, OUT_DIGIT, OUT_IDX, OUT_FIRST, OUT_LAST};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s idx%0d {v,digit,idx,first,last}: got %h required %h", tag, k, got, want);
      end
      if (k == chg_idx)  DIGITS = chg_bank;
      if (k == drop_idx) EN = 1'b0;
      if (k == stall_idx) begin
        OUT_READY = 1'b0;
        repeat (3) begin
          step();
          got = {OUT_VALID, OUT_DIGIT, OUT_IDX, OUT_FIRST, OUT_LAST};
          total++;
          if (got !== want) begin
            bad++;
            $display("FAIL %s stall idx%0d: got %h required %h", tag, k, got, want);
          end
        end
        OUT_READY = 1'b1;
      end
      step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; OUT_READY = 1'b1;
    DIGITS = to_bank(36'h123456789);
    repeat (3) step();
    total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst valid: got %b required 0", OUT_VALID); end
    total++; if (OUT_DIGIT !== '0)   begin bad++; $display("FAIL rst digit: got %h required 0", OUT_DIGIT); end
    total++; if (OUT_IDX !== 4'd0)   begin bad++; $display("FAIL rst idx: got %h required 0", OUT_IDX); end
    total++; if (OUT_FIRST !== 1'b0) begin bad++; $display("FAIL rst first: got %b required 0", OUT_FIRST); end
    total++; if (OUT_LAST !== 1'b0)  begin bad++; $display("FAIL rst last: got %b required 0", OUT_LAST); end
    total++; if (BUSY !== 1'b0)      begin bad++; $display("FAIL rst busy: got %b required 0", BUSY); end
    total++; if (BCD_ERR !== 1'b0)   begin bad++; $display("FAIL rst bcd_err: got %b required 0", BCD_ERR); end
    total++; if (FRAME_CNT !== 8'd0) begin bad++; $display("FAIL rst frame_cnt: got %0d required 0", FRAME_CNT); end
  endtask

  task automatic test_basic();
    RST = 1'b0; EN = 1'b1;
    step();
    total++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL snap cycle {valid,busy}: got %b%b required 01", OUT_VALID, BUSY);
    end
    recv_frame(to_bank(36'h123456789), -1, -1, '0, -1, "basic");
    total++;
    if (FRAME_CNT !== 8'd1 || OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL basic end {cnt,valid,busy}: got %0d %b %b required 1 0 1", FRAME_CNT, OUT_VALID, BUSY);
    end
  endtask

  task automatic test_backpressure();
    recv_frame(to_bank(36'h123456789), 5, -1, '0, -1, "bp");
    total++; if (FRAME_CNT !== 8'd2) begin bad++; $display("FAIL bp frame_cnt: got %0d required 2", FRAME_CNT); end
  endtask

  task automatic test_gap();
    int n;
    int busy_low;
    n = 0; busy_low = 0;
    while (OUT_VALID === 1'b0 && n < 20) begin
      if (BUSY !== 1'b1) busy_low++;
      step();
      n++;
    end
    total++; if (n != GAP_CYC + 1) begin bad++; $display("FAIL gap idle cycles: got %0d required %0d", n, GAP_CYC + 1); end
    total++; if (busy_low != 0)    begin bad++; $display("FAIL gap busy low cycles: got %0d required 0", busy_low); end
  endtask

  task automatic test_midchange();
    logic [BW-1:0] b42;
    logic [BW-1:0] e42;
    b42 = to_bank(36'h000000042);
`ifdef LZ_BLANK_EN
    e42 = {{7{5'h1F}}, 5'd4, 5'd2};
`else
    e42 = {{7{5'd0}}, 5'd4, 5'd2};
`endif
    recv_frame(to_bank(36'h123456789), -1, 4, b42, -1, "mid");
    recv_frame(e42, -1, -1, '0, -1, "new");
    total++; if (FRAME_CNT !== 8'd4) begin bad++; $display("FAIL mid frame_cnt: got %0d required 4", FRAME_CNT); end
  endtask

  task automatic test_en_drop();
    int            n;
    logic [BW-1:0] e42;
`ifdef LZ_BLANK_EN
    e42 = {{7{5'h1F}}, 5'd4, 5'd2};
`else
    e42 = {{7{5'd0}}, 5'd4, 5'd2};
`endif
    recv_frame(e42, -1, -1, '0, 3, "drop");
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++; if (n != GAP_CYC) begin bad++; $display("FAIL drop busy cycles after frame: got %0d required %0d", n, GAP_CYC); end
    repeat (5) step();
    total++;
    if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL drop idle {busy,valid}: got %b%b required 00", BUSY, OUT_VALID);
    end
    total++; if (FRAME_CNT !== 8'd5) begin bad++; $display("FAIL drop frame_cnt: got %0d required 5", FRAME_CNT); end
  endtask

  task automatic test_bcd_err();
    logic [BW-1:0] bc;
    total++; if (BCD_ERR !== 1'b0) begin bad++; $display("FAIL bcd_err before: got %b required 0", BCD_ERR); end
    bc = to_bank(36'h1C3456789);
    bc[DW-1] = 1'b1;
    DIGITS = bc;
    EN = 1'b1;
    recv_frame(bc, -1, -1, '0, -1, "bcd");
    total++; if (BCD_ERR !== 1'b1) begin bad++; $display("FAIL bcd_err set: got %b required 1", BCD_ERR); end
    DIGITS = to_bank(36'h123456789);
    recv_frame(to_bank(36'h123456789), -1, -1, '0, -1, "sticky");
    total++; if (BCD_ERR !== 1'b1)   begin bad++; $display("FAIL bcd_err sticky: got %b required 1", BCD_ERR); end
    total++; if (FRAME_CNT !== 8'd7) begin bad++; $display("FAIL sticky frame_cnt: got %0d required 7", FRAME_CNT); end
  endtask

  task automatic test_reset_mid();
    int            n;
    logic [DW+16:0] got;
    n = 0;
    while (OUT_VALID !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL rstmid start: valid got %b required 1", OUT_VALID); end
    repeat (2) step();
    RST = 1'b1;
    step();
    got = {OUT_VALID, OUT_DIGIT, OUT_IDX, OUT_FIRST, OUT_LAST, BUSY, BCD_ERR, FRAME_CNT};
    total++; if (got !== '0) begin bad++; $display("FAIL rstmid outputs: got %h required 0", got); end
    step();
    total++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rstmid hold {valid,busy}: got %b%b required 00", OUT_VALID, BUSY);
    end
    RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    while (!(z_valid === 1'b1 && z_last === 1'b1) && n < 40) begin
      step();
      n++;
    end
    total++; if (z_last !== 1'b1) begin bad++; $display("FAIL b2b first last: got %b required 1", z_last); end
    step();
    n = 1;
    while (!(z_valid === 1'b1 && z_last === 1'b1) && n < 40) begin
      step();
      n++;
    end
    total++; if (n != NDIG + 1) begin bad++; $display("FAIL b2b frame period: got %0d required %0d", n, NDIG + 1); end
    total++;
    if ({z_digit, z_idx, z_first, z_busy, z_bcd_err, z_frame_cnt} !== {5'd9, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1}) begin
      bad++;
      $display("FAIL b2b last digit {digit,idx,first,busy,err,cnt}: got %h %h %b %b %b %0d required 09 0 0 1 0 1",
               z_digit, z_idx, z_first, z_busy, z_bcd_err, z_frame_cnt);
    end
  endtask

  task automatic test_wrap();
    int   seen;
    int   cyc;
    logic last_x;
    RST = 1'b1; EN = 1'b1; OUT_READY = 1'b1;
    step();
    RST = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 256 && cyc < 8000) begin
      last_x = OUT_VALID && OUT_LAST && OUT_READY;
      step();
      cyc++;
      if (last_x) begin
        seen++;
        if (seen == 255) begin
          total++; if (FRAME_CNT !== 8'd255) begin bad++; $display("FAIL wrap at 255: got %0d required 255", FRAME_CNT); end
        end
      end
    end
    total++; if (seen != 256)        begin bad++; $display("FAIL wrap frames seen: got %0d required 256", seen); end
    total++; if (FRAME_CNT !== 8'd0) begin bad++; $display("FAIL wrap to zero: got %0d required 0", FRAME_CNT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_midchange();
    test_en_drop();
    test_bcd_err();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    EN = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
